// File: rtl/vector_pkg.sv
// Shared vector-op definitions: opcode map, lane geometry and op classification.
package vector_pkg;

  localparam int LANES  = 4;
  localparam int WORD_W = 32;

  typedef logic [LANES-1:0][WORD_W-1:0] vec_t;

  typedef enum logic [4:0] {
    VADD    = 5'h03, VSUB  = 5'h04, VMUL   = 5'h05, VDOT  = 5'h06,
    VDOTA   = 5'h07, VINDX = 5'h08, VREDUCE = 5'h09, VFMA = 5'h0A,
    VABS    = 5'h0B, VNEG  = 5'h0C, VSCALE = 5'h0D, VSHUF = 5'h0E,
    VCMP    = 5'h0F, VSEL  = 5'h10, VMAX   = 5'h11, VMIN  = 5'h12
  } op_e;

  function automatic logic is_legal_op(input logic [4:0] op);
    return (op >= VADD) && (op <= VMIN);
  endfunction

  // Ops whose architectural result is the scalar rout rather than the vector.
  function automatic logic is_scalar_op(input logic [4:0] op);
    return (op == VDOT) || (op == VDOTA) || (op == VINDX) || (op == VREDUCE);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; read data is the head entry (show-ahead).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp, rp;
  logic             do_wr, do_rd;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= nxt(wp);
      if (do_rd) rp <= nxt(rp);
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !clr) mem[wp] <= wr_data;
  end

endmodule

// File: rtl/vector_alu_issue.sv
// Issue/tracking front end for the fixed-latency vector ALU: credit-gated accept,
// tag shift register matching ALU latency, in-order response FIFO, flush drain.
module vector_alu_issue
  import vector_pkg::*;
#(
  parameter int LATENCY = 9,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [7:0]        req_imm,
  input  vec_t              req_v1,
  input  vec_t              req_v2,
  input  logic [WORD_W-1:0] req_r1,
  input  logic [WORD_W-1:0] req_r2,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              flush,
  output logic              alu_en,
  output logic [4:0]        alu_op,
  output logic [7:0]        alu_imm,
  output vec_t              alu_v1,
  output vec_t              alu_v2,
  output logic [WORD_W-1:0] alu_r1,
  output logic [WORD_W-1:0] alu_r2,
  input  vec_t              alu_vout,
  input  logic [WORD_W-1:0] alu_rout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_scalar,
  output logic              rsp_err,
  output vec_t              rsp_vout,
  output logic [WORD_W-1:0] rsp_rout,
  output logic              busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(LATENCY + 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             scalar;
    logic             err;
  } meta_t;

  typedef struct packed {
    meta_t             meta;
    vec_t              vout;
    logic [WORD_W-1:0] rout;
  } rsp_t;

  typedef enum logic {RUN, FLUSH} state_e;

  state_e           state;
  logic [CW-1:0]    credits;
  logic [DW-1:0]    drain;
  logic             acc, pop, legal;
  meta_t            meta_in;
  logic [LATENCY:1] vld_pipe;
  meta_t            meta_pipe [LATENCY:1];
  rsp_t             wr_rsp, head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty;

  // flush gates ready combinationally so a same-cycle request is never taken.
  assign req_ready = alu_en && (state == RUN) && (credits != '0) && !flush;
  assign acc       = req_valid && req_ready;
  assign rsp_valid = (state == RUN) && !fifo_empty;
  assign pop       = rsp_valid && rsp_ready && !flush;
  assign legal     = is_legal_op(req_op);
  assign meta_in   = '{tag: req_tag, scalar: legal && is_scalar_op(req_op), err: !legal};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      credits <= CW'(DEPTH);
      drain   <= '0;
      alu_en  <= 1'b0;
    end else begin
      alu_en <= 1'b1;
      if (flush) begin
        state   <= FLUSH;
        credits <= CW'(DEPTH);
        drain   <= DW'(LATENCY);
      end else begin
        if (state == FLUSH) begin
          if (drain <= DW'(1)) begin
            state <= RUN;
            drain <= '0;
          end else begin
            drain <= drain - 1'b1;
          end
        end
        case ({acc, pop})
          2'b10:   credits <= credits - 1'b1;
          2'b01:   credits <= credits + 1'b1;
          default: credits <= credits;
        endcase
      end
    end
  end

  // Illegal ops leave the ALU inputs untouched; their result is zeroed at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op  <= '0;
      alu_imm <= '0;
      alu_v1  <= '0;
      alu_v2  <= '0;
      alu_r1  <= '0;
      alu_r2  <= '0;
    end else if (acc && legal) begin
      alu_op  <= req_op;
      alu_imm <= req_imm;
      alu_v1  <= req_v1;
      alu_v2  <= req_v2;
      alu_r1  <= req_r1;
      alu_r2  <= req_r2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 1; i <= LATENCY; i++) meta_pipe[i] <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
      for (int i = 1; i <= LATENCY; i++) meta_pipe[i] <= '0;
    end else begin
      vld_pipe     <= {vld_pipe[LATENCY-1:1], acc};
      meta_pipe[1] <= meta_in;
      for (int i = 2; i <= LATENCY; i++) meta_pipe[i] <= meta_pipe[i-1];
    end
  end

  always_comb begin
    wr_rsp      = '0;
    wr_rsp.meta = meta_pipe[LATENCY];
    if (!meta_pipe[LATENCY].err) begin
      wr_rsp.vout = alu_vout;
      wr_rsp.rout = alu_rout;
    end
  end

  sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .wr_en   (vld_pipe[LATENCY] && !fifo_full),
    .wr_data (wr_rsp),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rsp_tag    = rsp_valid ? head.meta.tag    : '0;
  assign rsp_scalar = rsp_valid ? head.meta.scalar : 1'b0;
  assign rsp_err    = rsp_valid ? head.meta.err    : 1'b0;
  assign rsp_vout   = rsp_valid ? head.vout        : '0;
  assign rsp_rout   = rsp_valid ? head.rout        : '0;
  assign busy       = (state == FLUSH) || (|vld_pipe) || (fifo_count != '0);

endmodule

// File: tb/tb_vector_alu_issue.sv
// Directed bench: behavioural ALU pipeline, response scoreboard, flush and reset checks.
module tb_vector_alu_issue;
  import vector_pkg::*;

  localparam int LATENCY = 9;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 5;
  localparam int ALU_ST  = LATENCY - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, flush = 1'b0, rsp_ready = 1'b1;
  logic req_ready, alu_en, rsp_valid, rsp_scalar, rsp_err, busy;
  logic [4:0] req_op = '0, alu_op;
  logic [7:0] req_imm = '0, alu_imm;
  vec_t req_v1 = '0, req_v2 = '0, alu_v1, alu_v2, alu_vout, rsp_vout;
  logic [31:0] req_r1 = '0, req_r2 = '0, alu_r1, alu_r2, alu_rout, rsp_rout;
  logic [TAG_W-1:0] req_tag = '0, rsp_tag;

  typedef struct packed {vec_t v; logic [31:0] r;} ares_t;
  typedef struct packed {logic [4:0] tag; logic scalar; logic err; vec_t v; logic [31:0] r;} exp_t;

  ares_t apipe [ALU_ST];
  exp_t  sb [$];
  int    n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  vector_alu_issue #(.LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_imm(req_imm), .req_v1(req_v1), .req_v2(req_v2),
    .req_r1(req_r1), .req_r2(req_r2), .req_tag(req_tag), .flush(flush),
    .alu_en(alu_en), .alu_op(alu_op), .alu_imm(alu_imm), .alu_v1(alu_v1),
    .alu_v2(alu_v2), .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_vout(alu_vout),
    .alu_rout(alu_rout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_tag(rsp_tag), .rsp_scalar(rsp_scalar), .rsp_err(rsp_err),
    .rsp_vout(rsp_vout), .rsp_rout(rsp_rout), .busy(busy)
  );

  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == '0) return 0.0;
    d = {b[31], 11'(b[30:23]) - 11'd127 + 11'd1023, b[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return '0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd1023 + 11'd127), d[51:29]};
  endfunction

  // Behavioural ALU: fp32 add/dot for VADD/VDOT, an arbitrary bit mix otherwise.
  function automatic ares_t alu_f(input logic [4:0] op, input vec_t v1, input vec_t v2,
                                  input logic [31:0] r1, input logic [31:0] r2);
    ares_t a;
    real   s;
    a = '0;
    s = 0.0;
    if (op == VADD) begin
      for (int i = 0; i < LANES; i++) a.v[i] = r2f(f2r(v1[i]) + f2r(v2[i]));
    end else if (op == VDOT) begin
      for (int i = 0; i < LANES; i++) s = s + f2r(v1[i]) * f2r(v2[i]);
      a.r = r2f(s);
    end else begin
      a.v = v1 ^ v2;
      a.r = r1 + r2;
    end
    return a;
  endfunction

  always @(posedge clk) begin
    apipe[0] <= alu_f(alu_op, alu_v1, alu_v2, alu_r1, alu_r2);
    for (int i = 1; i < ALU_ST; i++) apipe[i] <= apipe[i-1];
  end
  assign alu_vout = apipe[ALU_ST-1].v;
  assign alu_rout = apipe[ALU_ST-1].r;

  task automatic chk(input string name, input logic [191:0] obs, input logic [191:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Response monitor, sampled late in the low phase.
  always @(negedge clk) begin
    #4;
    if (rst_n && rsp_valid && rsp_ready && !flush) begin
      chk("rsp_expected", 192'(sb.size() != 0), 192'(1));
      if (sb.size() != 0) chk("rsp_record", 192'({rsp_tag, rsp_scalar, rsp_err, rsp_vout, rsp_rout}),
                              192'(sb.pop_front()));
    end
  end

  task automatic send(input logic [4:0] op, input logic [4:0] tag, input vec_t v1, input vec_t v2,
                      input logic [31:0] r1, input logic [31:0] r2, output bit ok);
    exp_t  e;
    ares_t a;
    req_op = op; req_tag = tag; req_v1 = v1; req_v2 = v2; req_r1 = r1; req_r2 = r2;
    req_imm = 8'(tag); req_valid = 1'b1;
    #1;
    ok = req_ready;
    if (ok) begin
      a = alu_f(op, v1, v2, r1, r2);
      e = '0;
      e.tag = tag;
      if (op < 5'h03 || op > 5'h12) e.err = 1'b1;
      else begin
        e.scalar = (op >= 5'h06 && op <= 5'h09);
        e.v = a.v;
        e.r = a.r;
      end
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [4:0] op, input logic [4:0] tag, output bit ok);
    vec_t a, b;
    for (int i = 0; i < LANES; i++) begin a[i] = $urandom; b[i] = $urandom; end
    send(op, tag, a, b, $urandom, $urandom, ok);
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin @(negedge clk); cyc++; end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 100) begin @(negedge clk); t++; end
    chk(name, 192'(sb.size() == 0 && !busy), 192'(1));
  endtask

  // With the response side stalled, only DEPTH of nreq back-to-back requests get in.
  task automatic fill_check(input logic [4:0] base, input int nreq, input string name);
    int acc = 0;
    bit ok;
    rsp_ready = 1'b0;
    for (int i = 0; i < nreq; i++) begin
      send_rand(VSUB, base + 5'(i), ok);
      if (ok) acc++;
    end
    chk({name, "_accepted"}, 192'(acc), 192'(DEPTH));
    #1 chk({name, "_ready_low"}, 192'(req_ready), 192'(0));
    repeat (LATENCY + 2) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    #1 chk({name, "_ready_after_pop"}, 192'(req_ready), 192'(1));
    wait_drain({name, "_drain"});
  endtask

  initial begin
    vec_t v1, v2, exp_v;
    int   cyc;
    bit   ok;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outputs", 192'({req_ready, alu_en, rsp_valid, busy, alu_op, alu_v1, rsp_tag}), 192'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 192'({req_ready, alu_en}), 192'(2'b11));

    // vadd: lanes 1..4 + 0.5
    v1 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    v2 = {4{32'h3F000000}};
    exp_v = {32'h40900000, 32'h40600000, 32'h40200000, 32'h3FC00000};
    send(VADD, 5'd3, v1, v2, 32'h0, 32'h0, ok);
    wait_rsp(cyc);
    chk("vadd_latency", 192'(cyc), 192'(LATENCY + 1));
    chk("vadd_vout", 192'(rsp_vout), 192'(exp_v));
    chk("vadd_tag_scalar", 192'({rsp_tag, rsp_scalar, rsp_err}), 192'({5'd3, 2'b00}));
    wait_drain("vadd_drain");

    // vdot: 1.0 lanes -> 4.0 scalar
    v1 = {4{32'h3F800000}};
    send(VDOT, 5'd7, v1, v1, 32'h0, 32'h0, ok);
    wait_rsp(cyc);
    chk("vdot_rout", 192'(rsp_rout), 192'(32'h40800000));
    chk("vdot_tag_scalar", 192'({rsp_tag, rsp_scalar}), 192'({5'd7, 1'b1}));
    wait_drain("vdot_drain");

    fill_check(5'd10, 6, "credit_fill");

    // Illegal op between two vadds keeps order and returns its credit
    send(VADD, 5'd1, v1, v2, 32'h0, 32'h0, ok);
    send(5'h1F, 5'd2, v1, v2, 32'h5, 32'h6, ok);
    chk("illegal_accepted", 192'(ok), 192'(1));
    send(VADD, 5'd3, v2, v2, 32'h0, 32'h0, ok);
    wait_drain("illegal_drain");
    fill_check(5'd20, 5, "credits_after_err");

    // Flush 4 cycles after first accept; a same-cycle request is refused
    for (int i = 0; i < 3; i++) send_rand(VMUL, 5'(10 + i), ok);
    @(negedge clk);
    flush = 1'b1;
    req_valid = 1'b1;
    req_tag = 5'd20;
    #1 chk("flush_blocks_req", 192'(req_ready), 192'(0));
    sb.delete();
    @(negedge clk);
    flush = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      #1 chk("flush_ready_low", 192'({req_ready, rsp_valid, busy}), 192'(3'b001));
      @(negedge clk);
    end
    #1 chk("flush_exit", 192'({req_ready, busy}), 192'(2'b10));
    repeat (12) begin
      @(negedge clk);
      #1 chk("flush_no_rsp", 192'(rsp_valid), 192'(0));
    end

    // Asynchronous reset mid-flight
    send_rand(VADD, 5'd4, ok);
    send_rand(VSUB, 5'd5, ok);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outputs", 192'({req_ready, alu_en, rsp_valid, busy, alu_op, alu_v1, alu_r1}), 192'(0));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LATENCY + 3) begin
      @(negedge clk);
      #1 chk("rst_no_stale", 192'(rsp_valid), 192'(0));
    end
    @(negedge clk);
    send(VADD, 5'd9, v1, v2, 32'h0, 32'h0, ok);
    wait_rsp(cyc);
    chk("post_rst_latency", 192'(cyc), 192'(LATENCY + 1));
    wait_drain("post_rst_drain");
    fill_check(5'd24, 5, "post_rst_credits");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
